// File: rtl/input_debounce_sync.sv
// input_debounce_sync
// Brings WIDTH raw asynchronous inputs into the clk domain through a
// multi-flop synchroniser per bit. Each bit is then debounced on its own
// counter, so dout only follows a bit after it has held a new level for
// STABLE_CYCLES consecutive evaluations. Registered rise/fall/changed pulses
// coincide with the cycle dout updates. en freezes the debounce state but
// never the synchroniser.

module input_debounce_sync #(
  parameter int WIDTH         = 3,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // sync_q[0] samples din; sync_q[SYNC_STAGES-1] is the settled level
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] s;

  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0] dout_d;
  logic [WIDTH-1:0] rise_d;
  logic [WIDTH-1:0] fall_d;

  assign s = sync_q[SYNC_STAGES-1];

  // Synchroniser chain: shifts every cycle out of reset, regardless of en
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      sync_q[0] <= din;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  // Per-bit debounce decision: a mismatch must survive to the terminal count
  // before dout follows; any agreement in between throws the count away
  always_comb begin
    dout_d = dout;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
    end
    if (en) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (s[i] == dout[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_TERM) begin
          dout_d[i] = s[i];
          cnt_d[i]  = '0;
          rise_d[i] = s[i];
          fall_d[i] = ~s[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end
    end
  end

  // Debounce state and edge pulses, all updated together so pulses line up
  // with the dout change
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
      dout    <= '0;
      rise    <= '0;
      fall    <= '0;
      changed <= 1'b0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      dout    <= dout_d;
      rise    <= rise_d;
      fall    <= fall_d;
      changed <= |(rise_d | fall_d);
    end
  end

endmodule

// File: tb/tb_input_debounce_sync.sv
// tb_input_debounce_sync
// Directed scenarios for input_debounce_sync with default parameters
// (WIDTH=3, SYNC_STAGES=2, STABLE_CYCLES=4). Inputs are driven 1 time unit
// after a rising edge; outputs are sampled at the same point.

module tb_input_debounce_sync;

  logic       clk;
  logic       rst;
  logic       en;
  logic [2:0] din;
  logic [2:0] dout;
  logic [2:0] rise;
  logic [2:0] fall;
  logic       changed;

  int checks;
  int failures;

  bit pat [0:8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

  input_debounce_sync #(
    .WIDTH(3),
    .SYNC_STAGES(2),
    .STABLE_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .din(din),
    .dout(dout),
    .rise(rise),
    .fall(fall),
    .changed(changed)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold reset over two edges with din already applied, release mid-cycle;
  // the next tick is edge 1
  task automatic do_reset(input logic [2:0] d);
    rst = 1'b0;
    en  = 1'b1;
    din = d;
    tick();
    tick();
    rst = 1'b1;
  endtask

  // Reset clears everything; din=101 at release appears at edge 6
  task automatic test_reset();
    rst = 1'b1;
    en  = 1'b1;
    din = 3'b000;
    #2 rst = 1'b0;
    din = 3'b101;
    tick();
    tick();
    checks++;
    if ({dout, rise, fall, changed} !== 10'b0) begin
      failures++;
      $display("[TB] FAIL reset_hold: got dout=%b rise=%b fall=%b changed=%b expected all 0", dout, rise, fall, changed);
    end
    rst = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (e <= 5) begin
        checks++;
        if (dout !== 3'b000) begin
          failures++;
          $display("[TB] FAIL reset_release_edge%0d: got dout=%b expected 000", e, dout);
        end
      end else if (e == 6) begin
        checks++;
        if (dout !== 3'b101 || rise !== 3'b101 || fall !== 3'b000 || changed !== 1'b1) begin
          failures++;
          $display("[TB] FAIL reset_release_edge6: got dout=%b rise=%b fall=%b changed=%b expected 101 101 000 1", dout, rise, fall, changed);
        end
      end else begin
        checks++;
        if (dout !== 3'b101 || rise !== 3'b000 || changed !== 1'b0) begin
          failures++;
          $display("[TB] FAIL reset_release_edge7: got dout=%b rise=%b changed=%b expected 101 000 0", dout, rise, changed);
        end
      end
    end
  endtask

  // A 3-cycle high on din[1] is rejected; a 4-cycle high is accepted
  task automatic test_short_pulse();
    do_reset(3'b000);
    repeat (3) tick();
    din = 3'b010;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (e == 3) din = 3'b000;
      checks++;
      if (dout !== 3'b000 || changed !== 1'b0) begin
        failures++;
        $display("[TB] FAIL short3_edge%0d: got dout=%b changed=%b expected 000 0", e, dout, changed);
      end
    end
    din = 3'b010;
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (e == 4) din = 3'b000;
      if (e <= 5) begin
        checks++;
        if (dout !== 3'b000 || changed !== 1'b0) begin
          failures++;
          $display("[TB] FAIL short4_edge%0d: got dout=%b changed=%b expected 000 0", e, dout, changed);
        end
      end else if (e == 6) begin
        checks++;
        if (dout !== 3'b010 || rise !== 3'b010 || changed !== 1'b1) begin
          failures++;
          $display("[TB] FAIL short4_edge6: got dout=%b rise=%b changed=%b expected 010 010 1", dout, rise, changed);
        end
      end else begin
        checks++;
        if (dout !== 3'b010 || rise !== 3'b000 || changed !== 1'b0) begin
          failures++;
          $display("[TB] FAIL short4_edge%0d: got dout=%b rise=%b changed=%b expected 010 000 0", e, dout, rise, changed);
        end
      end
    end
  endtask

  // din[0] bounces; only the final 4-long run is accepted, rising at edge 11
  task automatic test_bounce();
    int rises;
    rises = 0;
    do_reset(3'b000);
    repeat (3) tick();
    din = {2'b00, pat[0]};
    for (int e = 1; e <= 14; e++) begin
      tick();
      din = (e < 9) ? {2'b00, pat[e]} : 3'b001;
      if (rise[0] === 1'b1) rises++;
      if (e == 10) begin
        checks++;
        if (dout !== 3'b000) begin
          failures++;
          $display("[TB] FAIL bounce_edge10: got dout=%b expected 000", dout);
        end
      end
      if (e == 11) begin
        checks++;
        if (dout !== 3'b001 || rise !== 3'b001) begin
          failures++;
          $display("[TB] FAIL bounce_edge11: got dout=%b rise=%b expected 001 001", dout, rise);
        end
      end
    end
    checks++;
    if (rises !== 1) begin
      failures++;
      $display("[TB] FAIL bounce_rise_count: got %0d expected 1", rises);
    end
  endtask

  // 111 -> 010 on one edge: bits 0 and 2 fall together with one changed pulse
  task automatic test_simultaneous();
    int pulses;
    pulses = 0;
    do_reset(3'b111);
    repeat (8) tick();
    checks++;
    if (dout !== 3'b111) begin
      failures++;
      $display("[TB] FAIL simul_setup: got dout=%b expected 111", dout);
    end
    din = 3'b010;
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (changed === 1'b1) pulses++;
      if (e == 5) begin
        checks++;
        if (dout !== 3'b111) begin
          failures++;
          $display("[TB] FAIL simul_edge5: got dout=%b expected 111", dout);
        end
      end else if (e == 6) begin
        checks++;
        if (dout !== 3'b010 || fall !== 3'b101 || rise !== 3'b000 || changed !== 1'b1) begin
          failures++;
          $display("[TB] FAIL simul_edge6: got dout=%b fall=%b rise=%b changed=%b expected 010 101 000 1", dout, fall, rise, changed);
        end
      end else if (e == 7) begin
        checks++;
        if (fall !== 3'b000 || changed !== 1'b0) begin
          failures++;
          $display("[TB] FAIL simul_edge7: got fall=%b changed=%b expected 000 0", fall, changed);
        end
      end
    end
    checks++;
    if (pulses !== 1) begin
      failures++;
      $display("[TB] FAIL simul_changed_count: got %0d expected 1", pulses);
    end
  endtask

  // en=0 freezes dout/cnt and suppresses pulses; counting resumes from the
  // held count when en returns
  task automatic test_enable();
    do_reset(3'b000);
    repeat (3) tick();
    en  = 1'b0;
    din = 3'b100;
    for (int e = 1; e <= 10; e++) begin
      tick();
      checks++;
      if (dout !== 3'b000 || rise !== 3'b000 || changed !== 1'b0) begin
        failures++;
        $display("[TB] FAIL en_off_edge%0d: got dout=%b rise=%b changed=%b expected 000 000 0", e, dout, rise, changed);
      end
    end
    en = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      tick();
      if (e < 4) begin
        checks++;
        if (dout !== 3'b000) begin
          failures++;
          $display("[TB] FAIL en_on_edge%0d: got dout=%b expected 000", e, dout);
        end
      end else begin
        checks++;
        if (dout !== 3'b100 || rise !== 3'b100 || changed !== 1'b1) begin
          failures++;
          $display("[TB] FAIL en_on_edge4: got dout=%b rise=%b changed=%b expected 100 100 1", dout, rise, changed);
        end
      end
    end
    // Freeze with count 2 held on bit 0, then resume
    do_reset(3'b000);
    repeat (3) tick();
    din = 3'b001;
    repeat (4) tick();
    en = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      tick();
      checks++;
      if (dout !== 3'b000 || changed !== 1'b0) begin
        failures++;
        $display("[TB] FAIL en_hold_edge%0d: got dout=%b changed=%b expected 000 0", e, dout, changed);
      end
    end
    en = 1'b1;
    tick();
    checks++;
    if (dout !== 3'b000) begin
      failures++;
      $display("[TB] FAIL en_resume_edge1: got dout=%b expected 000", dout);
    end
    tick();
    checks++;
    if (dout !== 3'b001 || rise !== 3'b001) begin
      failures++;
      $display("[TB] FAIL en_resume_edge2: got dout=%b rise=%b expected 001 001", dout, rise);
    end
  endtask

  // Async reset between edges while bit 2 is mid-count and a pulse is high
  task automatic test_reset_midcount();
    do_reset(3'b000);
    repeat (3) tick();
    din = 3'b011;
    tick();
    din = 3'b111;
    repeat (5) tick();
    checks++;
    if (dout !== 3'b011 || rise !== 3'b011 || changed !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midrst_setup: got dout=%b rise=%b changed=%b expected 011 011 1", dout, rise, changed);
    end
    #3 rst = 1'b0;
    #1;
    checks++;
    if ({dout, rise, fall, changed} !== 10'b0) begin
      failures++;
      $display("[TB] FAIL midrst_async: got dout=%b rise=%b fall=%b changed=%b expected all 0", dout, rise, fall, changed);
    end
    din = 3'b011;
    tick();
    tick();
    rst = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (e == 5) begin
        checks++;
        if (dout !== 3'b000) begin
          failures++;
          $display("[TB] FAIL midrst_edge5: got dout=%b expected 000", dout);
        end
      end else if (e == 6) begin
        checks++;
        if (dout !== 3'b011 || rise !== 3'b011) begin
          failures++;
          $display("[TB] FAIL midrst_edge6: got dout=%b rise=%b expected 011 011", dout, rise);
        end
      end else if (e == 7) begin
        checks++;
        if (dout !== 3'b011 || rise !== 3'b000) begin
          failures++;
          $display("[TB] FAIL midrst_edge7: got dout=%b rise=%b expected 011 000", dout, rise);
        end
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_short_pulse();
    test_bounce();
    test_simultaneous();
    test_enable();
    test_reset_midcount();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
